calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 172 +++++++++++++++++
 tb/tb_calc_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Multi-cycle 4-bit ADD/SUB/MUL/DIV sequencer that time-shares an external
// 4-bit adder-subtractor (repeated addition for MUL, restoring subtraction for DIV).
module calc_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] au_a,
  output logic [3:0] au_b,
  output logic       au_sign,
  input  logic [3:0] au_sum,
  input  logic       au_carry,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic [3:0] remainder,
  output logic       carry,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_op;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_acc;
  logic [3:0] r_cnt;
  logic [3:0] r_q;
  logic       r_ovf;
  logic [3:0] r_result;
  logic [3:0] r_remainder;
  logic       r_carry;
  logic       r_err;
  logic [3:0] w_au_a;
  logic [3:0] w_au_b;
  logic       w_au_sign;

  // r_acc is the MUL partial product or the DIV running remainder
  always_comb begin
    w_next    = r_state;
    w_au_a    = 4'd0;
    w_au_b    = 4'd0;
    w_au_sign = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = EXEC;
      end
      EXEC: begin
        case (r_op)
          OP_ADD, OP_SUB: begin
            w_au_a    = r_a;
            w_au_b    = r_b;
            w_au_sign = r_op[0];
            w_next    = DONE;
          end
          OP_MUL: begin
            if (r_cnt != 4'd0) begin
              w_au_a = r_acc;
              w_au_b = r_a;
            end else begin
              w_next = DONE;
            end
          end
          default: begin
            if (r_b == 4'd0) begin
              w_next = DONE;
            end else begin
              w_au_a    = r_acc;
              w_au_b    = r_b;
              w_au_sign = 1'b1;
              if (!au_carry) w_next = DONE;
            end
          end
        endcase
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_op        <= 2'd0;
      r_a         <= 4'd0;
      r_b         <= 4'd0;
      r_acc       <= 4'd0;
      r_cnt       <= 4'd0;
      r_q         <= 4'd0;
      r_ovf       <= 1'b0;
      r_result    <= 4'd0;
      r_remainder <= 4'd0;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_acc <= (op == OP_DIV) ? a : 4'd0;
            r_cnt <= b;
            r_q   <= 4'd0;
            r_ovf <= 1'b0;
          end
        end
        EXEC: begin
          case (r_op)
            OP_ADD, OP_SUB: begin
              // In subtract mode the adder reports "no borrow"; flip it into a borrow flag
              r_result    <= au_sum;
              r_carry     <= au_carry ^ r_op[0];
              r_remainder <= 4'd0;
              r_err       <= 1'b0;
            end
            OP_MUL: begin
              if (r_cnt != 4'd0) begin
                r_acc <= au_sum;
                r_ovf <= r_ovf | au_carry;
                r_cnt <= r_cnt - 4'd1;
              end else begin
                r_result    <= r_acc;
                r_carry     <= r_ovf;
                r_remainder <= 4'd0;
                r_err       <= 1'b0;
              end
            end
            default: begin
              if (r_b == 4'd0) begin
                r_result    <= 4'd0;
                r_remainder <= r_a;
                r_carry     <= 1'b0;
                r_err       <= 1'b1;
              end else if (au_carry) begin
                r_acc <= au_sum;
                r_q   <= r_q + 4'd1;
              end else begin
                r_result    <= r_q;
                r_remainder <= r_acc;
                r_carry     <= 1'b0;
                r_err       <= 1'b0;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign au_a      = w_au_a;
  assign au_b      = w_au_b;
  assign au_sign   = w_au_sign;
  assign busy      = (r_state == EXEC);
  assign done      = (r_state == DONE);
  assign result    = r_result;
  assign remainder = r_remainder;
  assign carry     = r_carry;
  assign err       = r_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized self-checking bench for calc_sequencer; results, latency and the
// per-cycle adder-subtractor drive are predicted from arithmetic rules.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] au_a;
  logic [3:0] au_b;
  logic       au_sign;
  logic [3:0] au_sum;
  logic       au_carry;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic [3:0] remainder;
  logic       carry;
  logic       err;

  int checks = 0;
  int errors = 0;

  calc_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .au_a(au_a), .au_b(au_b), .au_sign(au_sign), .au_sum(au_sum), .au_carry(au_carry),
    .busy(busy), .done(done), .result(result), .remainder(remainder),
    .carry(carry), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit adder-subtractor; in subtract mode carry means "no borrow"
  always_comb begin
    if (au_sign) begin
      au_sum   = 4'(int'(au_a) - int'(au_b));
      au_carry = (au_a >= au_b);
    end else begin
      au_sum   = 4'(int'(au_a) + int'(au_b));
      au_carry = ((int'(au_a) + int'(au_b)) > 15);
    end
  end

  // Runs one request from an idle cycle; leaves the bench 1 time unit after the edge into IDLE
  task automatic exec_op(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y, input bit poke);
    logic [3:0] eRes, eRem, expA, expB;
    logic       eCarry, eErr, expS;
    int         lat, n, j;
    bit         seen;
    eRes = 4'd0; eRem = 4'd0; eCarry = 1'b0; eErr = 1'b0; lat = 2;
    case (o)
      2'd0: begin eRes = 4'(int'(x) + int'(y)); eCarry = (int'(x) + int'(y)) > 15; end
      2'd1: begin eRes = 4'(int'(x) - int'(y)); eCarry = (x < y); end
      2'd2: begin eRes = 4'(int'(x) * int'(y)); eCarry = (int'(x) * int'(y)) > 15; lat = int'(y) + 2; end
      default: begin
        if (y == 4'd0) begin eRem = x; eErr = 1'b1; end
        else begin eRes = x / y; eRem = x % y; lat = int'(x / y) + 2; end
      end
    endcase
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || au_a !== 4'd0 || au_b !== 4'd0 || au_sign !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_au: busy=%b done=%b au=%h/%h/%b required 0/0/0/0/0", busy, done, au_a, au_b, au_sign);
    end
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
    n = 1; seen = 0;
    while (n <= 20) begin
      if (done === 1'b1) begin seen = 1; break; end
      j = n - 1;
      expA = 4'd0; expB = 4'd0; expS = 1'b0;
      case (o)
        2'd0, 2'd1: if (j == 0) begin expA = x; expB = y; expS = o[0]; end
        2'd2: if (j < int'(y)) begin expA = 4'(int'(x) * j); expB = x; end
        default: if (y != 4'd0 && j <= int'(x / y)) begin
          expA = 4'(int'(x) - j * int'(y)); expB = y; expS = 1'b1;
        end
      endcase
      checks++;
      if (au_a !== expA || au_b !== expB || au_sign !== expS || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL exec_au op=%0d a=%0d b=%0d cyc=%0d: au=%0d/%0d/%b busy=%b required %0d/%0d/%b busy=1",
                 o, x, y, j, au_a, au_b, au_sign, busy, expA, expB, expS);
      end
      if (poke && n == 1) begin
        start = 1'b1; op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL done_timeout op=%0d a=%0d b=%0d: no done within 20 cycles, required latency %0d", o, x, y, lat);
      return;
    end
    if (n != lat) begin
      errors++;
      $display("[TB] FAIL latency op=%0d a=%0d b=%0d: done at k+%0d required k+%0d", o, x, y, n, lat);
    end
    checks++;
    if (result !== eRes || remainder !== eRem || carry !== eCarry || err !== eErr || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL outputs op=%0d a=%0d b=%0d: res=%0d rem=%0d c=%b e=%b busy=%b required %0d %0d %b %b 0",
               o, x, y, result, remainder, carry, err, busy, eRes, eRem, eCarry, eErr);
    end
    checks++;
    if (au_a !== 4'd0 || au_b !== 4'd0 || au_sign !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_au: au=%0d/%0d/%b required 0/0/0", au_a, au_b, au_sign);
    end
    if (poke) begin
      start = 1'b1; op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== eRes || remainder !== eRem || carry !== eCarry || err !== eErr) begin
      errors++;
      $display("[TB] FAIL after_done op=%0d: done=%b busy=%b res=%0d rem=%0d c=%b e=%b required 0 0 %0d %0d %b %b",
               o, done, busy, result, remainder, carry, err, eRes, eRem, eCarry, eErr);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; op = 2'd0; a = 4'd0; b = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result, remainder, carry, err, au_a, au_b, au_sign} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b res=%0d rem=%0d c=%b e=%b au=%0d/%0d/%b required all 0",
               busy, done, result, remainder, carry, err, au_a, au_b, au_sign);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    exec_op(2'd0, 4'd9, 4'd8, 0);
    exec_op(2'd0, 4'd15, 4'd15, 0);
    exec_op(2'd0, 4'd2, 4'd3, 0);
  endtask

  task automatic test_sub();
    exec_op(2'd1, 4'd3, 4'd5, 0);
    exec_op(2'd1, 4'd5, 4'd3, 0);
    exec_op(2'd1, 4'd0, 4'd0, 0);
  endtask

  task automatic test_mul();
    exec_op(2'd2, 4'd3, 4'd5, 0);
    exec_op(2'd2, 4'd4, 4'd4, 0);
    exec_op(2'd2, 4'd7, 4'd0, 0);
    exec_op(2'd2, 4'd15, 4'd15, 0);
    exec_op(2'd2, 4'd1, 4'd15, 0);
  endtask

  task automatic test_div();
    exec_op(2'd3, 4'd13, 4'd4, 0);
    exec_op(2'd3, 4'd2, 4'd7, 0);
    exec_op(2'd3, 4'd9, 4'd0, 0);
    exec_op(2'd3, 4'd15, 4'd1, 0);
    exec_op(2'd3, 4'd0, 4'd5, 0);
  endtask

  task automatic test_ignored_start();
    exec_op(2'd2, 4'd2, 4'd5, 1);
    exec_op(2'd3, 4'd14, 4'd3, 1);
    exec_op(2'd0, 4'd7, 4'd6, 1);
  endtask

  task automatic test_reset_abort();
    bit sawDone;
    exec_op(2'd0, 4'd9, 4'd8, 0);
    sawDone = 0;
    start = 1'b1; op = 2'd2; a = 4'd3; b = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (done === 1'b1) sawDone = 1; end
    start = 1'b1; op = 2'd0; a = 4'd5; b = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    if (done === 1'b1) sawDone = 1;
    repeat (3) begin @(posedge clk); #1; if (done === 1'b1) sawDone = 1; end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_busy: busy=%b required 1 before reset", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, remainder, carry, err, au_a, au_b, au_sign} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL abort_reset: busy=%b done=%b res=%0d rem=%0d c=%b e=%b au=%0d/%0d/%b required all 0",
               busy, done, result, remainder, carry, err, au_a, au_b, au_sign);
    end
    repeat (2) begin @(posedge clk); #1; if (done === 1'b1) sawDone = 1; end
    reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; if (done === 1'b1) sawDone = 1; end
    checks++;
    if (sawDone || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: sawDone=%b busy=%b required 0 0", sawDone, busy);
    end
    exec_op(2'd0, 4'd1, 4'd1, 0);
  endtask

  task automatic test_back_to_back();
    exec_op(2'd2, 4'd5, 4'd3, 0);
    exec_op(2'd3, 4'd11, 4'd2, 0);
    exec_op(2'd1, 4'd1, 4'd9, 0);
    exec_op(2'd0, 4'd8, 4'd8, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      exec_op(2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
